alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Issue-side controller for the 32-bit MIPS ALU. It accepts raw instructions with register operands and decodes them into the ALU's 4-bit operation code and operand pair. It buffers them in a small FIFO, presents the head entry to the ALU, and turns the returned ALU result into a registered write-back. It sits between the ID stage and the ALU/write-back path of the lab CPU.

## Interface
- `DEPTH`, default 2: FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: FIFO can accept.
- `instr` in 32: MIPS instruction word.
- `rs_data` in 32: value of GPR[rs].
- `rt_data` in 32: value of GPR[rt].
- `alu_op` out 4: ALU operation code for the head entry.
- `alu_a` out 32: ALU operand1.
- `alu_b` out 32: ALU operand2.
- `alu_result` in 32: combinational ALU result for `alu_a`/`alu_b`/`alu_op`.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: downstream accepts the head this cycle.
- `wb_valid` out 1: registered write-back strobe.
- `wb_rd` out 5: destination register.
- `wb_data` out 32: write-back value.
- `illegal` out 1: one-cycle pulse for an unsupported instruction.
- `ovf_trap` out 1: one-cycle pulse for signed overflow. Present only with the macro; otherwise tied to 0.

## Operation
- Push when `in_valid & in_ready`. Decode happens at push; the entry stores {op, a, b, rd, kind}.
- Pop (fire) when `out_valid & out_ready`. `alu_op`/`alu_a`/`alu_b` always reflect the head entry. When empty, they hold zero.
- R-type (opcode 0) funct map, with a=rs, b=rt, rd=instr[15:11]:
  - add 100000→0010, addu 100001→0000
  - sub 100010→0011, subu 100011→0001
  - and→0100, or→0101, xor→0110, nor→0111
  - slt 101010→1011, sltu 101011→1010
  - sllv 000100→1110, srlv 000110→1101, srav 000111→1100
- Fixed shifts: sll 000000→1110, srl 000010→1101, sra 000011→1100. For these, a = zero-extended shamt (instr[10:6]) and b = rt.
- I-type map, with a=rs, rd=instr[20:16]:
  - addi 001000→0010 (sext), addiu 001001→0000 (sext)
  - slti 001010→1011 (sext), sltiu 001011→1010 (sext)
  - andi→0100, ori→0101, xori→0110, all zero-extended
  - lui 001111→1000, b = zero-extended imm
- Any other encoding is illegal: it is pushed with op 0000 and a=b=0. On fire, `illegal` pulses and no write-back occurs.
- Write-back: on fire of a legal entry with rd≠0, next cycle `wb_valid`=1, `wb_rd`=rd, `wb_data`=`alu_result` sampled at fire. rd=0 gives no `wb_valid`.
- Signed overflow is computed inside this block; the ALU's overflow_flag is not used.
  - add: a[31]==b[31] && r[31]!=a[31].
  - sub: a[31]!=b[31] && r[31]!=a[31].
  - Applies only to add/addi/sub.

## Timing
- Reset (`rst_n` low at an edge): FIFO empties; `out_valid`, `wb_valid`, `illegal`, `ovf_trap`, `wb_rd`, `wb_data` all 0. `in_ready`=0 while `rst_n` is low, and 1 on the first cycle after release. Reset mid-transfer drops all entries and any pending write-back.
- `in_ready` = count<DEPTH, derived from registered count. It does not depend on `out_ready`, so a full FIFO refuses a push even in a pop cycle.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged, order is preserved.
- Input-to-`out_valid` latency: 1 cycle (entry visible the cycle after push).
- Fire-to-`wb_valid`/`illegal`/`ovf_trap` latency: 1 cycle. Each is a single-cycle pulse per fired entry. Back-to-back fires give back-to-back pulses.
- Pointers wrap modulo DEPTH. Throughput is 1 instruction/cycle when the FIFO is neither empty nor full.

## Configuration
- `ALU_ISSUE_OVF_TRAP_EN` defined:
  - add/addi/sub overflow on fire pulses `ovf_trap` one cycle later.
  - `wb_valid` is suppressed for that entry; rd is not written.
- Not defined:
  - `ovf_trap` is constant 0.
  - add/addi/sub write back the wrapped result like addu/subu.

## Test plan
- Reset, then push `addu $3,$1,$2` with rs=5, rt=7, out_ready=1 → alu_op=0000, a=5, b=7. One cycle after fire: wb_valid=1, wb_rd=3, wb_data=12.
- Push `sra $4,$5,4` with rt=0x80000000 → alu_op=1100, alu_a=4, alu_b=0x80000000. wb_data=0xF8000000, wb_rd=4.
- Hold out_ready=0 and push 3 instructions → in_ready low after 2 pushes (DEPTH=2). The third is accepted only after one fire. Order is preserved.
- Macro on: `add` with rs=0x7FFFFFFF, rt=1 → ovf_trap pulse, no wb_valid. Macro off: wb_data=0x80000000.
- Push opcode 0x3F → illegal pulses one cycle after fire, no wb_valid. A following `ori $2,$0,0xFFFF` gives b=0x0000FFFF, wb_data=0x0000FFFF.
- Drop rst_n with 2 entries queued → next cycle out_valid=0, no wb_valid. in_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/alu_issue_if.sv
// ============================================================================
// Module      : alu_issue_if
// Description : Issue/ALU/write-back bundle between the ID stage and the ALU.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic        ovf_trap;

    modport slave (
        input  in_valid, instr, rs_data, rt_data, alu_result, out_ready,
        output in_ready, alu_op, alu_a, alu_b, out_valid,
               wb_valid, wb_rd, wb_data, illegal, ovf_trap
    );

    modport master (
        output in_valid, instr, rs_data, rt_data, alu_result, out_ready,
        input  in_ready, alu_op, alu_a, alu_b, out_valid,
               wb_valid, wb_rd, wb_data, illegal, ovf_trap
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Decodes MIPS ALU instructions into a FIFO, issues the head to
//               the ALU and registers the write-back. Optional overflow trap
//               enabled by macro ALU_ISSUE_OVF_TRAP_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
    parameter int DEPTH = 2
) (
    input  wire         clk,
    input  wire         rst_n,
    alu_issue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] c_kind_norm = 2'd0;
    localparam logic [1:0] c_kind_ill  = 2'd1;
    localparam logic [1:0] c_kind_add  = 2'd2;
    localparam logic [1:0] c_kind_sub  = 2'd3;

    // ---------------------------------------------------------------- decode
    logic [5:0]  w_opcode, w_funct;
    logic [31:0] w_sext, w_zext, w_shamt;
    logic [3:0]  w_dec_op;
    logic [31:0] w_dec_a, w_dec_b;
    logic [4:0]  w_dec_rd;
    logic [1:0]  w_dec_kind;
    logic        w_unused_rs_field;

    assign w_opcode = bus.instr[31:26];
    assign w_funct  = bus.instr[5:0];
    assign w_sext   = {{16{bus.instr[15]}}, bus.instr[15:0]};
    assign w_zext   = {16'h0000, bus.instr[15:0]};
    assign w_shamt  = {27'd0, bus.instr[10:6]};
    assign w_unused_rs_field = &{1'b0, bus.instr[25:21]};

    always_comb begin
        w_dec_op   = 4'b0000;
        w_dec_a    = bus.rs_data;
        w_dec_b    = bus.rt_data;
        w_dec_rd   = bus.instr[15:11];
        w_dec_kind = c_kind_norm;
        if (w_opcode == 6'b000000) begin
            case (w_funct)
                6'b100000: begin w_dec_op = 4'b0010; w_dec_kind = c_kind_add; end
                6'b100001: w_dec_op = 4'b0000;
                6'b100010: begin w_dec_op = 4'b0011; w_dec_kind = c_kind_sub; end
                6'b100011: w_dec_op = 4'b0001;
                6'b100100: w_dec_op = 4'b0100;
                6'b100101: w_dec_op = 4'b0101;
                6'b100110: w_dec_op = 4'b0110;
                6'b100111: w_dec_op = 4'b0111;
                6'b101010: w_dec_op = 4'b1011;
                6'b101011: w_dec_op = 4'b1010;
                6'b000100: w_dec_op = 4'b1110;
                6'b000110: w_dec_op = 4'b1101;
                6'b000111: w_dec_op = 4'b1100;
                6'b000000: begin w_dec_op = 4'b1110; w_dec_a = w_shamt; end
                6'b000010: begin w_dec_op = 4'b1101; w_dec_a = w_shamt; end
                6'b000011: begin w_dec_op = 4'b1100; w_dec_a = w_shamt; end
                default:   w_dec_kind = c_kind_ill;
            endcase
        end else begin
            w_dec_rd = bus.instr[20:16];
            case (w_opcode)
                6'b001000: begin w_dec_op = 4'b0010; w_dec_b = w_sext; w_dec_kind = c_kind_add; end
                6'b001001: begin w_dec_op = 4'b0000; w_dec_b = w_sext; end
                6'b001010: begin w_dec_op = 4'b1011; w_dec_b = w_sext; end
                6'b001011: begin w_dec_op = 4'b1010; w_dec_b = w_sext; end
                6'b001100: begin w_dec_op = 4'b0100; w_dec_b = w_zext; end
                6'b001101: begin w_dec_op = 4'b0101; w_dec_b = w_zext; end
                6'b001110: begin w_dec_op = 4'b0110; w_dec_b = w_zext; end
                6'b001111: begin w_dec_op = 4'b1000; w_dec_b = w_zext; end
                default:   w_dec_kind = c_kind_ill;
            endcase
        end
        // Illegal entries travel as a harmless op 0 with zero operands.
        if (w_dec_kind == c_kind_ill) begin
            w_dec_op = 4'b0000;
            w_dec_a  = 32'd0;
            w_dec_b  = 32'd0;
            w_dec_rd = 5'd0;
        end
    end

    // ------------------------------------------------------------------ FIFO
    logic [3:0]  r_op_q   [DEPTH];
    logic [31:0] r_a_q    [DEPTH];
    logic [31:0] r_b_q    [DEPTH];
    logic [4:0]  r_rd_q   [DEPTH];
    logic [1:0]  r_kind_q [DEPTH];

    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_in_ready, w_out_valid, w_push, w_fire;

    assign w_in_ready  = rst_n & (r_count < (PW+1)'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_fire      = w_out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_q[r_wr_ptr]   <= w_dec_op;
            r_a_q[r_wr_ptr]    <= w_dec_a;
            r_b_q[r_wr_ptr]    <= w_dec_b;
            r_rd_q[r_wr_ptr]   <= w_dec_rd;
            r_kind_q[r_wr_ptr] <= w_dec_kind;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_fire) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_fire})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    logic [4:0] w_head_rd;
    logic [1:0] w_head_kind;

    assign w_head_rd   = r_rd_q[r_rd_ptr];
    assign w_head_kind = r_kind_q[r_rd_ptr];

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.alu_op    = w_out_valid ? r_op_q[r_rd_ptr] : 4'b0000;
    assign bus.alu_a     = w_out_valid ? r_a_q[r_rd_ptr]  : 32'd0;
    assign bus.alu_b     = w_out_valid ? r_b_q[r_rd_ptr]  : 32'd0;

    // ------------------------------------------------------------ write-back
    logic w_trap;

`ifdef ALU_ISSUE_OVF_TRAP_EN
    logic w_a31, w_b31, w_r31;
    logic r_ovf_trap;

    assign w_a31  = bus.alu_a[31];
    assign w_b31  = bus.alu_b[31];
    assign w_r31  = bus.alu_result[31];
    assign w_trap = w_fire & (w_r31 != w_a31) &
                    (((w_head_kind == c_kind_add) & (w_a31 == w_b31)) |
                     ((w_head_kind == c_kind_sub) & (w_a31 != w_b31)));

    always_ff @(posedge clk) begin
        if (!rst_n) r_ovf_trap <= 1'b0;
        else        r_ovf_trap <= w_trap;
    end
    assign bus.ovf_trap = r_ovf_trap;
`else
    assign w_trap       = 1'b0;
    assign bus.ovf_trap = 1'b0;
`endif

    logic       w_wb_en;
    logic       r_wb_valid, r_illegal;
    logic [4:0] r_wb_rd;
    logic [31:0] r_wb_data;

    assign w_wb_en = w_fire & (w_head_kind != c_kind_ill) & (w_head_rd != 5'd0) & ~w_trap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_illegal  <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'd0;
        end else begin
            r_wb_valid <= w_wb_en;
            r_illegal  <= w_fire & (w_head_kind == c_kind_ill);
            if (w_wb_en) begin
                r_wb_rd   <= w_head_rd;
                r_wb_data <= bus.alu_result;
            end
        end
    end

    assign bus.wb_valid = r_wb_valid;
    assign bus.wb_rd    = r_wb_rd;
    assign bus.wb_data  = r_wb_data;
    assign bus.illegal  = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Directed vector bench for alu_issue_ctrl with a reference ALU.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_issue_if bus ();

    alu_issue_ctrl #(.DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU feeding alu_result
    always_comb begin
        case (bus.alu_op)
            4'b0000, 4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
            4'b0001, 4'b0011: bus.alu_result = bus.alu_a - bus.alu_b;
            4'b0100: bus.alu_result = bus.alu_a & bus.alu_b;
            4'b0101: bus.alu_result = bus.alu_a | bus.alu_b;
            4'b0110: bus.alu_result = bus.alu_a ^ bus.alu_b;
            4'b0111: bus.alu_result = ~(bus.alu_a | bus.alu_b);
            4'b1011: bus.alu_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            4'b1010: bus.alu_result = {31'd0, bus.alu_a < bus.alu_b};
            4'b1110: bus.alu_result = bus.alu_b << bus.alu_a[4:0];
            4'b1101: bus.alu_result = bus.alu_b >> bus.alu_a[4:0];
            4'b1100: bus.alu_result = $signed(bus.alu_b) >>> bus.alu_a[4:0];
            4'b1000: bus.alu_result = {bus.alu_b[15:0], 16'h0000};
            default: bus.alu_result = 32'd0;
        endcase
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        wbv;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
        logic        ovf;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_only(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.rs_data  = rs;
        bus.rt_data  = rt;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.instr = 32'd0;
        bus.rs_data = 32'd0;
        bus.rt_data = 32'd0;
        bus.out_ready = 1'b0;

        vecs[0]  = '{32'h00221821, 32'd5,        32'd7,        4'b0000, 32'd5,        32'd7,        1'b1, 5'd3,  32'd12,       1'b0, 1'b0};
        vecs[1]  = '{32'h00052103, 32'h12345678, 32'h80000000, 4'b1100, 32'd4,        32'h80000000, 1'b1, 5'd4,  32'hF8000000, 1'b0, 1'b0};
        vecs[2]  = '{32'hFC000000, 32'd9,        32'd9,        4'b0000, 32'd0,        32'd0,        1'b0, 5'd0,  32'd0,        1'b1, 1'b0};
        vecs[3]  = '{32'h3402FFFF, 32'd0,        32'd0,        4'b0101, 32'd0,        32'h0000FFFF, 1'b1, 5'd2,  32'h0000FFFF, 1'b0, 1'b0};
        vecs[4]  = '{32'h00E83022, 32'd10,       32'd3,        4'b0011, 32'd10,       32'd3,        1'b1, 5'd6,  32'd7,        1'b0, 1'b0};
        vecs[5]  = '{32'h0022482A, 32'hFFFFFFFF, 32'd1,        4'b1011, 32'hFFFFFFFF, 32'd1,        1'b1, 5'd9,  32'd1,        1'b0, 1'b0};
        vecs[6]  = '{32'h0022482B, 32'hFFFFFFFF, 32'd1,        4'b1010, 32'hFFFFFFFF, 32'd1,        1'b1, 5'd9,  32'd0,        1'b0, 1'b0};
        vecs[7]  = '{32'h3C051234, 32'h00000055, 32'd0,        4'b1000, 32'h00000055, 32'h00001234, 1'b1, 5'd5,  32'h12340000, 1'b0, 1'b0};
        vecs[8]  = '{32'h2027FFFF, 32'd5,        32'd0,        4'b0010, 32'd5,        32'hFFFFFFFF, 1'b1, 5'd7,  32'd4,        1'b0, 1'b0};
        vecs[9]  = '{32'h3020F0F0, 32'h0000FFFF, 32'd0,        4'b0100, 32'h0000FFFF, 32'h0000F0F0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0};
`ifdef ALU_ISSUE_OVF_TRAP_EN
        vecs[10] = '{32'h00221820, 32'h7FFFFFFF, 32'd1,        4'b0010, 32'h7FFFFFFF, 32'd1,        1'b0, 5'd0,  32'd0,        1'b0, 1'b1};
`else
        vecs[10] = '{32'h00221820, 32'h7FFFFFFF, 32'd1,        4'b0010, 32'h7FFFFFFF, 32'd1,        1'b1, 5'd3,  32'h80000000, 1'b0, 1'b0};
`endif
        vecs[11] = '{32'h00625004, 32'd8,        32'd1,        4'b1110, 32'd8,        32'd1,        1'b1, 5'd10, 32'h00000100, 1'b0, 1'b0};
        vecs[12] = '{32'h00225827, 32'd0,        32'd0,        4'b0111, 32'd0,        32'd0,        1'b1, 5'd11, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[13] = '{32'h382C8000, 32'd0,        32'd0,        4'b0110, 32'd0,        32'h00008000, 1'b1, 5'd12, 32'h00008000, 1'b0, 1'b0};

        // Reset state
        step();
        step();
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_wb_valid",  {31'd0, bus.wb_valid},  32'd0);
        chk("rst_illegal",   {31'd0, bus.illegal},   32'd0);
        chk("rst_ovf",       {31'd0, bus.ovf_trap},  32'd0);
        chk("rst_wb_data",   bus.wb_data,            32'd0);
        chk("rst_wb_rd",     {27'd0, bus.wb_rd},     32'd0);
        chk("rst_alu_a",     bus.alu_a,              32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready",  {31'd0, bus.in_ready},  32'd1);

        // One instruction at a time: decode visible next cycle, write-back one cycle after fire
        for (int i = 0; i < 14; i++) begin
            push_only(vecs[i].instr, vecs[i].rs, vecs[i].rt);
            chk($sformatf("v%0d_out_valid", i), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("v%0d_alu_op", i),    {28'd0, bus.alu_op},   {28'd0, vecs[i].op});
            chk($sformatf("v%0d_alu_a", i),     bus.alu_a,             vecs[i].a);
            chk($sformatf("v%0d_alu_b", i),     bus.alu_b,             vecs[i].b);
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            chk($sformatf("v%0d_wb_valid", i), {31'd0, bus.wb_valid}, {31'd0, vecs[i].wbv});
            chk($sformatf("v%0d_illegal", i),  {31'd0, bus.illegal},  {31'd0, vecs[i].ill});
            chk($sformatf("v%0d_ovf", i),      {31'd0, bus.ovf_trap}, {31'd0, vecs[i].ovf});
            chk($sformatf("v%0d_empty", i),    {31'd0, bus.out_valid}, 32'd0);
            if (vecs[i].wbv) begin
                chk($sformatf("v%0d_wb_rd", i),   {27'd0, bus.wb_rd}, {27'd0, vecs[i].rd});
                chk($sformatf("v%0d_wb_data", i), bus.wb_data,        vecs[i].data);
            end
            step();
            chk($sformatf("v%0d_pulse_end", i), {30'd0, bus.wb_valid, bus.illegal}, 32'd0);
        end

        // Full FIFO refuses a push even while popping; order preserved
        push_only(32'h00221821, 32'h11, 32'd0);
        push_only(32'h00221821, 32'h22, 32'd0);
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("full_head",     bus.alu_a,             32'h11);
        bus.in_valid = 1'b1;
        bus.instr    = 32'h00221821;
        bus.rs_data  = 32'h33;
        bus.rt_data  = 32'd0;
        bus.out_ready = 1'b1;
        step();
        chk("pop1_wb_data",  bus.wb_data,             32'h11);
        chk("pop1_head",     bus.alu_a,               32'h22);
        chk("pop1_in_ready", {31'd0, bus.in_ready},   32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("pop2_wb_valid", {31'd0, bus.wb_valid},   32'd1);
        chk("pop2_wb_data",  bus.wb_data,             32'h22);
        chk("pop2_head",     bus.alu_a,               32'h33);
        chk("pop2_out_valid",{31'd0, bus.out_valid},  32'd1);
        step();
        bus.out_ready = 1'b0;
        chk("pop3_wb_valid", {31'd0, bus.wb_valid},   32'd1);
        chk("pop3_wb_data",  bus.wb_data,             32'h33);
        chk("pop3_empty",    {31'd0, bus.out_valid},  32'd0);
        step();

        // Reset with two entries queued drops them and the pending write-back
        push_only(32'h00221821, 32'h44, 32'd0);
        push_only(32'h00221821, 32'h55, 32'd0);
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        step();
        chk("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mrst_wb_valid",  {31'd0, bus.wb_valid},  32'd0);
        chk("mrst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("mrst_wb_data",   bus.wb_data,            32'd0);
        rst_n = 1'b1;
        step();
        chk("mrel_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("mrel_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mrel_wb_valid",  {31'd0, bus.wb_valid},  32'd0);
        bus.out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
